flex_stp_deser: RTL and testbench
=================================

# flex_stp_deser

Parametrised serial-to-parallel deserializer that succeeds the single-lane flex shift register. It accepts LANES bits per shift, counts beats to frame complete words, and presents each finished word in a holding register with a valid/ready handshake. It sits between serial front-ends (e.g. bit-stream receivers) and word-oriented consumers in the datapath.

## Interface
- NUM_BITS, 8, word width; must be a multiple of LANES, ≥ 2.
- LANES, 1, serial bits accepted per shift; 1 ≤ LANES ≤ NUM_BITS.
- SHIFT_MSB, 1, 1 = new data enters at LSB and shifts toward MSB; 0 = enters at MSB and shifts toward LSB.
- FILL_VAL, 1'b1, bit value replicated into the shift register on reset and clear.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- shift_enable  input  1  shift serial_in into the register this cycle.
- serial_in  input  LANES  serial data for this shift.
- clear  input  1  synchronous frame restart; has priority over shift_enable.
- parallel_out  output  NUM_BITS  live shift-register contents.
- bit_count  output  max(1,$clog2(BEATS))  beats accepted in current word, where BEATS = NUM_BITS/LANES.
- word_out  output  NUM_BITS  last completed word (holding register).
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid=1.
- overflow  output  1  sticky overrun flag (see Configuration).

## Operation
- Shift (shift_enable=1, clear=0): SHIFT_MSB=1 -> sr <= {sr[NUM_BITS-LANES-1:0], serial_in}; SHIFT_MSB=0 -> sr <= {serial_in, sr[NUM_BITS-1:LANES]}. When LANES=NUM_BITS, sr <= serial_in.
- bit_count increments on each shift; on the shift with bit_count=BEATS-1 it wraps to 0 and the word completes.
- Completion: the post-shift value of sr is the completed word.
  - If word_valid=0, or word_valid=1 and word_ready=1 this cycle: word_out <= completed word; word_valid <= 1.
  - If word_valid=1 and word_ready=0: overrun. The new word is dropped, and word_out and word_valid are unchanged.
- Pop: word_valid=1 and word_ready=1 with no completion -> word_valid <= 0. word_out retains its value.
- clear: sr <= {NUM_BITS{FILL_VAL}}, bit_count <= 0. No completion occurs. word_out, word_valid and overflow are unaffected.
- shift_enable=0 and clear=0: sr and bit_count hold.
- Reset values: parallel_out = {NUM_BITS{FILL_VAL}}, bit_count = 0, word_out = 0, word_valid = 0, overflow = 0. Reset mid-word discards the partial word and any held word.

## Timing
- All state is registered. parallel_out and bit_count update one edge after shift_enable.
- word_valid rises on the same edge as the final shift. It is visible in the cycle after the last beat is presented.
- Maximum throughput is one word per BEATS enabled cycles. With LANES=NUM_BITS, one word per cycle is sustained only while word_ready=1.
- word_ready is sampled only when word_valid=1. word_out is stable while word_valid=1 and word_ready=0.

## Configuration
- FLEX_STP_OVF_EN defined: overflow is set on the edge of any overrun and stays set until rst. There is no other clear.
- FLEX_STP_OVF_EN undefined: overflow is tied to 0 and no detection logic is built. Overrun still drops the new word.

## Structure
- Package flex_stp_pkg holds:
  - function beats(NUM_BITS, LANES) and the count-width helper;
  - shift_dir_t enum (DIR_LSB_IN, DIR_MSB_IN) mapped from SHIFT_MSB.
- Sub-module flex_stp_core contains the shift register and beat counter, and emits a one-cycle word_done pulse with the completed word.
- The top level contains the holding register, handshake logic and overflow logic.

## Test plan
- Reset: assert rst mid-run -> parallel_out=8'hFF, bit_count=0, word_valid=0, word_out=0, overflow=0.
- Single-lane MSB (NUM_BITS=8, LANES=1, SHIFT_MSB=1): shift 1,0,1,0,0,1,0,1 -> word_out=8'hA5, word_valid=1 on the cycle after the 8th shift.
- Two-lane LSB (LANES=2, SHIFT_MSB=0): beats 2'b01, 2'b10, 2'b11, 2'b00 -> word_out=8'h39 after the 4th beat, with bit_count cycling 0→1→2→3→0.
- Backpressure (macro on, word_ready=0): complete 8'hA5, then 8'h3C.
  - Expected: word_out stays 8'hA5 and overflow=1.
  - Then raise word_ready for 1 cycle -> word_valid=0, and overflow stays 1.
- Simultaneous pop and completion: word_valid=1 with word_ready=1 on the final shift of 8'h5A -> word_valid stays 1 and word_out=8'h5A.
- Clear mid-word: 3 shifts, then clear=1 together with shift_enable=1.
  - Expected: parallel_out=8'hFF and bit_count=0.
  - Only after 8 further shifts -> word_valid=1.

Source files
------------

// File: rtl/flex_stp_pkg.sv
// flex_stp_pkg: shared types and sizing helpers for the flex_stp deserializer.
package flex_stp_pkg;

    // Where new serial data enters the shift register.
    typedef enum logic {
        DIR_LSB_IN = 1'b0,  // enters at LSB, shifts toward MSB
        DIR_MSB_IN = 1'b1   // enters at MSB, shifts toward LSB
    } shift_dir_t;

    // Number of shifts that make up one word.
    function automatic int beats(input int num_bits, input int lanes);
        return num_bits / lanes;
    endfunction

    // Width of the beat counter; never narrower than one bit.
    function automatic int cnt_w(input int n_beats);
        return (n_beats <= 2) ? 1 : $clog2(n_beats);
    endfunction

    // Map the SHIFT_MSB parameter onto the direction enum.
    function automatic shift_dir_t dir_of(input int shift_msb);
        return (shift_msb != 0) ? DIR_LSB_IN : DIR_MSB_IN;
    endfunction

endpackage

// File: rtl/flex_stp_core.sv
// flex_stp_core: multi-lane shift register plus beat counter. Emits a
// combinational one-cycle word_done_o pulse carrying the post-shift word.
module flex_stp_core
    import flex_stp_pkg::*;
#(
    parameter int   NUM_BITS  = 8,
    parameter int   LANES     = 1,
    parameter int   SHIFT_MSB = 1,
    parameter logic FILL_VAL  = 1'b1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       shift_enable_i,
    input  logic [LANES-1:0]                           serial_in_i,
    input  logic                                       clear_i,
    output logic [NUM_BITS-1:0]                        sr_o,
    output logic [cnt_w(beats(NUM_BITS, LANES))-1:0]   cnt_o,
    output logic                                       word_done_o,
    output logic [NUM_BITS-1:0]                        word_o
);

    localparam int         BEATS = beats(NUM_BITS, LANES);
    localparam int         CW    = cnt_w(BEATS);
    localparam shift_dir_t DIR   = dir_of(SHIFT_MSB);
    localparam logic [CW-1:0]       LAST = CW'(BEATS - 1);
    localparam logic [NUM_BITS-1:0] FILL = {NUM_BITS{FILL_VAL}};

    logic [NUM_BITS-1:0] sr_q, sr_d, sr_shift;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_beat;

    // Candidate register value if this cycle shifts.
    generate
        if (LANES == NUM_BITS) begin : g_full
            assign sr_shift = serial_in_i;
        end else if (DIR == DIR_LSB_IN) begin : g_lsb_in
            assign sr_shift = {sr_q[NUM_BITS-LANES-1:0], serial_in_i};
        end else begin : g_msb_in
            assign sr_shift = {serial_in_i, sr_q[NUM_BITS-1:LANES]};
        end
    endgenerate

    assign last_beat = (cnt_q == LAST);

    // Next-state: clear wins over shift; completion only on a real shift.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        word_done_o = 1'b0;
        if (clear_i) begin
            sr_d  = FILL;
            cnt_d = '0;
        end else if (shift_enable_i) begin
            sr_d        = sr_shift;
            cnt_d       = last_beat ? '0 : cnt_q + CW'(1);
            word_done_o = last_beat;
        end
    end

    // Shift register and beat counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= FILL;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_o   = sr_q;
    assign cnt_o  = cnt_q;
    assign word_o = sr_shift;

endmodule

// File: rtl/flex_stp_deser.sv
// flex_stp_deser: serial-to-parallel deserializer with a one-word holding
// register and valid/ready handshake. Define FLEX_STP_OVF_EN to build the
// sticky overrun flag; otherwise overflow is tied low.
module flex_stp_deser
    import flex_stp_pkg::*;
#(
    parameter int   NUM_BITS  = 8,
    parameter int   LANES     = 1,
    parameter int   SHIFT_MSB = 1,
    parameter logic FILL_VAL  = 1'b1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       shift_enable,
    input  logic [LANES-1:0]                           serial_in,
    input  logic                                       clear,
    output logic [NUM_BITS-1:0]                        parallel_out,
    output logic [cnt_w(beats(NUM_BITS, LANES))-1:0]   bit_count,
    output logic [NUM_BITS-1:0]                        word_out,
    output logic                                       word_valid,
    input  logic                                       word_ready,
    output logic                                       overflow
);

    logic                word_done;
    logic [NUM_BITS-1:0] core_word;
    logic [NUM_BITS-1:0] word_out_q, word_out_d;
    logic                word_valid_q, word_valid_d;

    flex_stp_core #(
        .NUM_BITS (NUM_BITS),
        .LANES    (LANES),
        .SHIFT_MSB(SHIFT_MSB),
        .FILL_VAL (FILL_VAL)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .shift_enable_i(shift_enable),
        .serial_in_i   (serial_in),
        .clear_i       (clear),
        .sr_o          (parallel_out),
        .cnt_o         (bit_count),
        .word_done_o   (word_done),
        .word_o        (core_word)
    );

    // Holding register: load when empty or being popped, else drop the word.
    always_comb begin
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        if (word_done) begin
            if (!word_valid_q || word_ready) begin
                word_out_d   = core_word;
                word_valid_d = 1'b1;
            end
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end
    end

    // Holding register and valid flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;

`ifdef FLEX_STP_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q | (word_done & word_valid_q & ~word_ready);

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_flex_stp_deser.sv
// tb_flex_stp_deser: directed, table-driven bench for flex_stp_deser using
// three instances (1-lane LSB-in, 2-lane MSB-in, full-width).
module tb_flex_stp_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: NUM_BITS=8, LANES=1, SHIFT_MSB=1
    logic       se_a = 0, si_a = 0, clr_a = 0, rdy_a = 0;
    logic [7:0] po_a, wo_a;
    logic [2:0] cnt_a;
    logic       v_a, ovf_a;
    // Instance B: NUM_BITS=8, LANES=2, SHIFT_MSB=0
    logic       se_b = 0, clr_b = 0, rdy_b = 0;
    logic [1:0] si_b = 0;
    logic [7:0] po_b, wo_b;
    logic [1:0] cnt_b;
    logic       v_b, ovf_b;
    // Instance C: NUM_BITS=8, LANES=8, SHIFT_MSB=1
    logic       se_c = 0, clr_c = 0, rdy_c = 0;
    logic [7:0] si_c = 0;
    logic [7:0] po_c, wo_c;
    logic [0:0] cnt_c;
    logic       v_c, ovf_c;

    flex_stp_deser #(.NUM_BITS(8), .LANES(1), .SHIFT_MSB(1), .FILL_VAL(1'b1)) u_a (
        .clk(clk), .rst(rst), .shift_enable(se_a), .serial_in(si_a), .clear(clr_a),
        .parallel_out(po_a), .bit_count(cnt_a), .word_out(wo_a), .word_valid(v_a),
        .word_ready(rdy_a), .overflow(ovf_a));

    flex_stp_deser #(.NUM_BITS(8), .LANES(2), .SHIFT_MSB(0), .FILL_VAL(1'b1)) u_b (
        .clk(clk), .rst(rst), .shift_enable(se_b), .serial_in(si_b), .clear(clr_b),
        .parallel_out(po_b), .bit_count(cnt_b), .word_out(wo_b), .word_valid(v_b),
        .word_ready(rdy_b), .overflow(ovf_b));

    flex_stp_deser #(.NUM_BITS(8), .LANES(8), .SHIFT_MSB(1), .FILL_VAL(1'b1)) u_c (
        .clk(clk), .rst(rst), .shift_enable(se_c), .serial_in(si_c), .clear(clr_c),
        .parallel_out(po_c), .bit_count(cnt_c), .word_out(wo_c), .word_valid(v_c),
        .word_ready(rdy_c), .overflow(ovf_c));

    typedef struct {
        logic       se, si, clr, rdy;
        logic [7:0] po;
        logic [2:0] cnt;
        logic       v;
        logic [7:0] wo;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   pass  = 0;
    logic ovf_exp;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic se, input logic si, input logic clr, input logic rdy,
                       input logic [7:0] po, input logic [2:0] cnt, input logic v,
                       input logic [7:0] wo);
        vec_t t;
        t.se = se; t.si = si; t.clr = clr; t.rdy = rdy;
        t.po = po; t.cnt = cnt; t.v = v; t.wo = wo;
        tbl.push_back(t);
    endtask

    // Shift one byte into A, first bit = MSB; ready only on the final beat.
    task automatic shift_byte_a(input logic [7:0] b, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            se_a = 1'b1; si_a = b[i]; rdy_a = (i == 0) ? rdy_last : 1'b0;
            tick();
        end
        se_a = 1'b0; rdy_a = 1'b0;
    endtask

    logic [1:0] b_beats [4];
    logic [7:0] b_po    [4];

    initial begin
`ifdef FLEX_STP_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        // ---- reset state ----
        rst = 1'b1;
        repeat (2) tick();
        chk("rst po", po_a, 8'hFF);
        chk("rst cnt", {5'd0, cnt_a}, 8'd0);
        chk("rst valid", {7'd0, v_a}, 8'd0);
        chk("rst wo", wo_a, 8'h00);
        chk("rst ovf", {7'd0, ovf_a}, 8'd0);
        rst = 1'b0;
        tick();

        // ---- table: A5 (MSB first), pop, 3C, then 5A with pop on final beat ----
        add(1,1,0,0, 8'hFF,1,0,8'h00); add(1,0,0,0, 8'hFE,2,0,8'h00);
        add(1,1,0,0, 8'hFD,3,0,8'h00); add(1,0,0,0, 8'hFA,4,0,8'h00);
        add(1,0,0,0, 8'hF4,5,0,8'h00); add(1,1,0,0, 8'hE9,6,0,8'h00);
        add(1,0,0,0, 8'hD2,7,0,8'h00); add(1,1,0,0, 8'hA5,0,1,8'hA5);
        add(0,0,0,0, 8'hA5,0,1,8'hA5); add(0,0,0,1, 8'hA5,0,0,8'hA5);
        add(1,0,0,0, 8'h4A,1,0,8'hA5); add(1,0,0,0, 8'h94,2,0,8'hA5);
        add(1,1,0,0, 8'h29,3,0,8'hA5); add(1,1,0,0, 8'h53,4,0,8'hA5);
        add(1,1,0,0, 8'hA7,5,0,8'hA5); add(1,1,0,0, 8'h4F,6,0,8'hA5);
        add(1,0,0,0, 8'h9E,7,0,8'hA5); add(1,0,0,0, 8'h3C,0,1,8'h3C);
        add(1,0,0,0, 8'h78,1,1,8'h3C); add(1,1,0,0, 8'hF1,2,1,8'h3C);
        add(1,0,0,0, 8'hE2,3,1,8'h3C); add(1,1,0,0, 8'hC5,4,1,8'h3C);
        add(1,1,0,0, 8'h8B,5,1,8'h3C); add(1,0,0,0, 8'h16,6,1,8'h3C);
        add(1,1,0,0, 8'h2D,7,1,8'h3C); add(1,0,0,1, 8'h5A,0,1,8'h5A);
        add(0,0,0,1, 8'h5A,0,0,8'h5A); add(0,1,0,0, 8'h5A,0,0,8'h5A);
        foreach (tbl[i]) begin
            se_a = tbl[i].se; si_a = tbl[i].si; clr_a = tbl[i].clr; rdy_a = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d po", i), po_a, tbl[i].po);
            chk($sformatf("row%0d cnt", i), {5'd0, cnt_a}, {5'd0, tbl[i].cnt});
            chk($sformatf("row%0d valid", i), {7'd0, v_a}, {7'd0, tbl[i].v});
            chk($sformatf("row%0d wo", i), wo_a, tbl[i].wo);
            chk($sformatf("row%0d ovf", i), {7'd0, ovf_a}, 8'd0);
        end
        se_a = 0; rdy_a = 0;

        // ---- backpressure: A5 held, 3C completes with ready low ----
        shift_byte_a(8'hA5, 1'b0);
        chk("bp first wo", wo_a, 8'hA5);
        chk("bp first ovf", {7'd0, ovf_a}, 8'd0);
        shift_byte_a(8'h3C, 1'b0);
        chk("bp held wo", wo_a, 8'hA5);
        chk("bp held valid", {7'd0, v_a}, 8'd1);
        chk("bp po", po_a, 8'h3C);
        chk("bp ovf", {7'd0, ovf_a}, {7'd0, ovf_exp});
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        chk("bp pop valid", {7'd0, v_a}, 8'd0);
        chk("bp pop wo", wo_a, 8'hA5);
        chk("bp pop ovf", {7'd0, ovf_a}, {7'd0, ovf_exp});
        tick();
        chk("bp sticky ovf", {7'd0, ovf_a}, {7'd0, ovf_exp});

        // ---- clear mid-word, clear has priority over shift ----
        for (int i = 0; i < 3; i++) begin
            se_a = 1'b1; si_a = (i == 1) ? 1'b0 : 1'b1;
            tick();
        end
        chk("pre-clr cnt", {5'd0, cnt_a}, 8'd3);
        se_a = 1'b1; si_a = 1'b0; clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr po", po_a, 8'hFF);
        chk("clr cnt", {5'd0, cnt_a}, 8'd0);
        chk("clr valid", {7'd0, v_a}, 8'd0);
        begin
            logic [7:0] pat;
            pat = 8'h96;
            for (int i = 7; i >= 1; i--) begin
                si_a = pat[i];
                tick();
            end
            chk("clr 7 valid", {7'd0, v_a}, 8'd0);
            chk("clr 7 cnt", {5'd0, cnt_a}, 8'd7);
            si_a = pat[0];
            tick();
        end
        se_a = 1'b0;
        chk("clr 8 valid", {7'd0, v_a}, 8'd1);
        chk("clr 8 wo", wo_a, 8'h96);

        // ---- two-lane, MSB-in: 01,10,11,00 -> 39 ----
        b_beats[0] = 2'b01; b_beats[1] = 2'b10; b_beats[2] = 2'b11; b_beats[3] = 2'b00;
        b_po[0] = 8'h7F; b_po[1] = 8'h9F; b_po[2] = 8'hE7; b_po[3] = 8'h39;
        chk("b cnt start", {6'd0, cnt_b}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            se_b = 1'b1; si_b = b_beats[i];
            tick();
            chk($sformatf("b beat%0d po", i), po_b, b_po[i]);
            chk($sformatf("b beat%0d cnt", i), {6'd0, cnt_b}, 8'((i + 1) % 4));
            chk($sformatf("b beat%0d valid", i), {7'd0, v_b}, (i == 3) ? 8'd1 : 8'd0);
        end
        se_b = 1'b0;
        chk("b wo", wo_b, 8'h39);

        // ---- full width: one word per cycle while ready, overrun when not ----
        se_c = 1'b1; rdy_c = 1'b1; si_c = 8'h11;
        tick();
        chk("c w1 wo", wo_c, 8'h11);
        chk("c w1 valid", {7'd0, v_c}, 8'd1);
        chk("c cnt", {7'd0, cnt_c}, 8'd0);
        si_c = 8'h22;
        tick();
        chk("c w2 wo", wo_c, 8'h22);
        chk("c w2 ovf", {7'd0, ovf_c}, 8'd0);
        rdy_c = 1'b0; si_c = 8'h33;
        tick();
        se_c = 1'b0;
        chk("c w3 wo", wo_c, 8'h22);
        chk("c w3 po", po_c, 8'h33);
        chk("c w3 valid", {7'd0, v_c}, 8'd1);
        chk("c w3 ovf", {7'd0, ovf_c}, {7'd0, ovf_exp});

        // ---- asynchronous reset mid-word ----
        se_a = 1'b1; si_a = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid rst po", po_a, 8'hFF);
        chk("mid rst cnt", {5'd0, cnt_a}, 8'd0);
        chk("mid rst valid", {7'd0, v_a}, 8'd0);
        chk("mid rst wo", wo_a, 8'h00);
        chk("mid rst ovf", {7'd0, ovf_a}, 8'd0);
        chk("mid rst c valid", {7'd0, v_c}, 8'd0);
        chk("mid rst c ovf", {7'd0, ovf_c}, 8'd0);
        chk("mid rst b po", po_b, 8'hFF);
        se_a = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
